// File: rtl/booth_pkg.sv
// Shared definitions for the Booth product accumulator: default widths,
// FSM state encoding and the accumulator saturation limits.
package booth_pkg;

    localparam int PROD_W_DEF = 32;
    localparam int ACC_W_DEF  = 34;
    localparam int LEN_DEF    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Most positive / most negative two's-complement values of the accumulator
    localparam logic [ACC_W_DEF-1:0] ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
    localparam logic [ACC_W_DEF-1:0] ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

endpackage

// File: rtl/booth_product_accumulator_if.sv
// Product input and group-sum output handshakes of the product accumulator.
interface booth_product_accumulator_if
    import booth_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
);
    logic              prod_valid;
    logic              prod_ready;
    logic [PROD_W-1:0] product;
    logic              clear;
    logic              acc_valid;
    logic              acc_ready;
    logic [ACC_W-1:0]  acc_out;
    logic              acc_sat;
    logic [7:0]        prod_cnt;

    modport master (
        output prod_valid, product, clear, acc_ready,
        input  prod_ready, acc_valid, acc_out, acc_sat, prod_cnt
    );

    modport slave (
        input  prod_valid, product, clear, acc_ready,
        output prod_ready, acc_valid, acc_out, acc_sat, prod_cnt
    );
endinterface

// File: rtl/booth_sat_adder.sv
// Combinational accumulator + sign-extended product add, clamped to the
// signed accumulator range, with an overflow flag.
module booth_sat_adder
    import booth_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] product,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);
    localparam int EXT_W = ACC_W + 1 - PROD_W;
    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W:0] wide_sum;

    // One guard bit: the top two bits disagree exactly when the result left range
    assign wide_sum = {acc[ACC_W-1], acc} + {{EXT_W{product[PROD_W-1]}}, product};
    assign ovf      = wide_sum[ACC_W] ^ wide_sum[ACC_W-1];

    always_comb begin
        sum = wide_sum[ACC_W-1:0];
        if (ovf) begin
            sum = wide_sum[ACC_W] ? SAT_MIN : SAT_MAX;
        end
    end
endmodule

// File: rtl/booth_product_accumulator.sv
// Sums fixed-length groups of signed products with saturation and hands each
// group sum downstream over a valid/ready handshake.
module booth_product_accumulator
    import booth_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int LEN    = LEN_DEF
) (
    input  logic clk,
    input  logic rst,
    booth_product_accumulator_if.slave bus
);
    state_t           state_reg, state_next;
    logic [ACC_W-1:0] acc_reg, acc_next;
    logic             sat_reg, sat_next;
    logic [7:0]       cnt_reg, cnt_next;
    logic             prod_ready_reg, prod_ready_next;
    logic             acc_valid_reg, acc_valid_next;

    logic [ACC_W-1:0] sum_w;
    logic             ovf_w;
    logic             accept;

    booth_sat_adder #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_sat_adder (
        .acc     (acc_reg),
        .product (bus.product),
        .sum     (sum_w),
        .ovf     (ovf_w)
    );

    assign accept = bus.prod_valid && prod_ready_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            acc_reg        <= '0;
            sat_reg        <= 1'b0;
            cnt_reg        <= 8'd0;
            prod_ready_reg <= 1'b0;
            acc_valid_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            acc_reg        <= acc_next;
            sat_reg        <= sat_next;
            cnt_reg        <= cnt_next;
            prod_ready_reg <= prod_ready_next;
            acc_valid_reg  <= acc_valid_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        sat_next   = sat_reg;
        cnt_next   = cnt_reg;
        unique case (state_reg)
            IDLE: state_next = ACC;
            ACC: begin
                // clear wins over a same-cycle accept: the product is dropped
                if (bus.clear) begin
                    acc_next = '0;
                    sat_next = 1'b0;
                    cnt_next = 8'd0;
                end else if (accept) begin
                    acc_next = sum_w;
                    sat_next = sat_reg | ovf_w;
                    cnt_next = cnt_reg + 8'd1;
                    if (cnt_reg + 8'd1 == LEN[7:0]) begin
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.clear || bus.acc_ready) begin
                    acc_next   = '0;
                    sat_next   = 1'b0;
                    cnt_next   = 8'd0;
                    state_next = ACC;
                end
            end
            default: state_next = IDLE;
        endcase
        // Handshake flags are registered copies of the state being entered
        prod_ready_next = (state_next == ACC);
        acc_valid_next  = (state_next == HOLD);
    end

    assign bus.prod_ready = prod_ready_reg;
    assign bus.acc_valid  = acc_valid_reg;
    assign bus.acc_out    = acc_reg;
    assign bus.acc_sat    = sat_reg;
    assign bus.prod_cnt   = cnt_reg;
endmodule
